fb_pixel_writer: RTL
====================

FB_PIXEL_WRITER -- requirements
Module: fb_pixel_writer

Interface
REQ-001 SHALL have parameter FRAME_PIXELS, default 76800, pixels per frame (320x240); legal range 1..262144.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, write-buffer entries; power of two, 2..16.
REQ-003 SHALL have port clock  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (low = reset).
REQ-005 SHALL have port pixel_in  input  24  pixel {R[7:0],G[7:0],B[7:0]} from the UART pixel assembler.
REQ-006 SHALL have port pixel_valid  input  1  one-cycle strobe qualifying pixel_in and pixel_addr.
REQ-007 SHALL have port pixel_addr  input  18  framebuffer address of pixel_in.
REQ-008 SHALL have port mem_grant  input  1  framebuffer write port granted by the display arbiter.
REQ-009 SHALL have port clear_flags  input  1  synchronous clear of sticky error flags.
REQ-010 SHALL have port mem_req  output  1  write-port request.
REQ-011 SHALL have port mem_we  output  1  write enable, one cycle per pixel.
REQ-012 SHALL have port mem_addr  output  18  write address.
REQ-013 SHALL have port mem_wdata  output  12  RGB444 write data.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse after the last pixel of a frame is written.
REQ-015 SHALL have port frame_count  output  8  completed frames, wraps 255->0.
REQ-016 SHALL have port overflow  output  1  sticky: pixel dropped because the FIFO was full.
REQ-017 SHALL have port addr_err  output  1  sticky: pixel dropped because pixel_addr >= FRAME_PIXELS.

Function
REQ-018 SHALL convert pixels by truncation: wdata = {R[7:4],G[7:4],B[7:4]}, computed at push.
REQ-019 SHALL push {pixel_addr, wdata} when pixel_valid=1, pixel_addr < FRAME_PIXELS and FIFO not full.
REQ-020 SHALL evaluate full at the start of the cycle; a push to a full FIFO is dropped and sets overflow, even if a pop occurs in the same cycle.
REQ-021 SHALL drop any pixel with pixel_addr >= FRAME_PIXELS and set addr_err, without touching FIFO contents.
REQ-022 SHALL support simultaneous push and pop on a non-full FIFO with occupancy unchanged; read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-023 SHALL implement FSM IDLE, REQ, WRITE; mem_req=1 in REQ and WRITE, 0 in IDLE.
REQ-024 IDLE->REQ SHALL occur when the FIFO is non-empty; otherwise the FSM stays in IDLE.
REQ-025 REQ->WRITE SHALL occur when mem_grant=1; otherwise the FSM stays in REQ indefinitely.
REQ-026 In WRITE, mem_we SHALL be 1 for exactly one cycle, with mem_addr/mem_wdata equal to the FIFO head, and the head SHALL pop.
REQ-027 After WRITE the FSM SHALL go to WRITE if post-pop occupancy is >0 and mem_grant=1, to REQ if occupancy >0 and mem_grant=0, else to IDLE.
REQ-028 When mem_we=0, mem_addr and mem_wdata SHALL hold their last written values.
REQ-029 Latency with an empty FIFO, FSM in IDLE and mem_grant held high SHALL be: pixel_valid at cycle t -> mem_we at cycle t+3.
REQ-030 Pixels SHALL be written in arrival order; sustained throughput SHALL be one pixel per cycle while mem_grant=1.
REQ-031 frame_done SHALL pulse in the cycle after a write with mem_addr = FRAME_PIXELS-1, and frame_count SHALL increment in that same cycle.
REQ-032 clear_flags=1 SHALL zero overflow and addr_err next cycle; a same-cycle set event SHALL take priority over clear.

Reset
REQ-033 While reset=0 at a clock edge, the block SHALL empty the FIFO and enter IDLE.
REQ-034 While reset=0 at a clock edge, it SHALL force mem_req, mem_we, frame_done, overflow and addr_err to 0, mem_addr to 0, mem_wdata to 0 and frame_count to 0.
REQ-035 Reset asserted mid-WRITE or mid-burst SHALL discard all buffered pixels, with no further mem_we until new pushes arrive.
REQ-036 Pixels presented during reset SHALL be ignored.

Structure
REQ-037 Package fb_pkg SHALL hold FB_ADDR_W=18, PIX_W=24, MEM_DATA_W=12, the state enum type, and the RGB888->RGB444 function.
REQ-038 The FIFO SHALL be a separate sub-module fb_wr_fifo (push/pop/full/empty, width FB_ADDR_W+MEM_DATA_W).

Verification
REQ-039 Single pixel: grant=1, pixel 0xF0A05C at addr 5 -> mem_we at t+3, mem_addr=5, mem_wdata=0xFA5.
REQ-040 Burst: grant=0, push 4 pixels at addrs 0..3, then grant=1 -> mem_req high, four consecutive mem_we cycles, addrs 0,1,2,3 in order.
REQ-041 Overflow: grant=0, push 5 pixels -> 5th dropped, overflow=1; clear_flags -> overflow=0; grant=1 -> exactly 4 writes.
REQ-042 Frame wrap: FRAME_PIXELS=4, write addrs 0..3 twice -> frame_done pulses twice, frame_count=2; addr 4 -> addr_err=1 and no write.
REQ-043 Grant drop: grant deasserted after the 2nd write of 4 -> FSM in REQ, no mem_we; grant restored -> writes 3 and 4.
REQ-044 Reset mid-burst: reset=0 during the 2nd of 4 writes -> all outputs at reset values next cycle, no further mem_we.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer pixel writer.
package fb_pkg;

    localparam int unsigned FB_ADDR_W  = 18;
    localparam int unsigned PIX_W      = 24;
    localparam int unsigned MEM_DATA_W = 12;
    localparam int unsigned ENTRY_W    = FB_ADDR_W + MEM_DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WRITE = 2'd2
    } fb_state_e;

    typedef struct packed {
        logic [FB_ADDR_W-1:0]  addr;
        logic [MEM_DATA_W-1:0] data;
    } fb_entry_t;

    // RGB888 -> RGB444 by keeping the top nibble of each channel
    function automatic logic [MEM_DATA_W-1:0] rgb888_to_444(input logic [PIX_W-1:0] pix);
        return {pix[23:20], pix[15:12], pix[7:4]};
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Small write buffer between the pixel assembler and the framebuffer port.
module fb_wr_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 30
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_c,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             do_push_c;
    logic             do_pop_c;

    // Qualify push/pop against the occupancy seen at the start of the cycle
    always_comb begin
        do_push_c = push && !full;
        do_pop_c  = pop && !empty;
        count_nxt = count + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
    end

    assign head_c = mem[rd_ptr];

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Storage array, no reset needed since occupancy gates every read
    always_ff @(posedge clock) begin
        if (do_push_c) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fb_pixel_writer.sv
// Buffers incoming pixels, converts to RGB444 and writes them to the framebuffer.
module fb_pixel_writer
    import fb_pkg::*;
#(
    parameter int unsigned FRAME_PIXELS = 76800,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [PIX_W-1:0]      pixel_in,
    input  logic                  pixel_valid,
    input  logic [FB_ADDR_W-1:0]  pixel_addr,
    input  logic                  mem_grant,
    input  logic                  clear_flags,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [FB_ADDR_W-1:0]  mem_addr,
    output logic [MEM_DATA_W-1:0] mem_wdata,
    output logic                  frame_done,
    output logic [7:0]            frame_count,
    output logic                  overflow,
    output logic                  addr_err
);

    localparam int unsigned LIM_W = FB_ADDR_W + 1;
    localparam logic [LIM_W-1:0]     FRAME_LIMIT = LIM_W'(FRAME_PIXELS);
    localparam logic [FB_ADDR_W-1:0] LAST_ADDR   = FB_ADDR_W'(FRAME_PIXELS - 1);

    fb_state_e        state;
    fb_entry_t        push_entry_c;
    fb_entry_t        head_entry_c;
    logic [ENTRY_W-1:0] head_raw_c;
    logic             fifo_full;
    logic             fifo_empty;
    logic             addr_ok_c;
    logic             push_c;
    logic             pop_c;
    logic             ovf_evt_c;
    logic             aerr_evt_c;

    // Input qualification and pop decision
    always_comb begin
        addr_ok_c         = ({1'b0, pixel_addr} < FRAME_LIMIT);
        push_c            = pixel_valid && addr_ok_c && !fifo_full;
        ovf_evt_c         = pixel_valid && addr_ok_c && fifo_full;
        aerr_evt_c        = pixel_valid && !addr_ok_c;
        push_entry_c.addr = pixel_addr;
        push_entry_c.data = rgb888_to_444(pixel_in);
        head_entry_c      = head_raw_c;
        pop_c             = mem_grant &&
                            ((state == ST_REQ) || ((state == ST_WRITE) && !fifo_empty));
    end

    fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_c),
        .push_data (push_entry_c),
        .pop       (pop_c),
        .head_c    (head_raw_c),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Write-port FSM; the head is popped on the edge that enters or stays in WRITE
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= ST_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= pop_c;
            if (pop_c) begin
                mem_addr  <= head_entry_c.addr;
                mem_wdata <= head_entry_c.data;
            end
            unique case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state   <= ST_REQ;
                        mem_req <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (mem_grant) state <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (fifo_empty) begin
                        state   <= ST_IDLE;
                        mem_req <= 1'b0;
                    end else if (!mem_grant) begin
                        state <= ST_REQ;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // End-of-frame pulse and frame counter follow the write of the last address
    always_ff @(posedge clock) begin
        if (!reset) begin
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= mem_we && (mem_addr == LAST_ADDR);
            if (mem_we && (mem_addr == LAST_ADDR)) frame_count <= frame_count + 8'd1;
        end
    end

    // Sticky error flags; a new event wins over a clear in the same cycle
    always_ff @(posedge clock) begin
        if (!reset) begin
            overflow <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            if (ovf_evt_c)        overflow <= 1'b1;
            else if (clear_flags) overflow <= 1'b0;
            if (aerr_evt_c)       addr_err <= 1'b1;
            else if (clear_flags) addr_err <= 1'b0;
        end
    end

endmodule
